// File: rtl/pop_timer_core.sv
// POP Ramsey pulse sequencer: pump / MW / free-precession / MW / probe, repeating,
// with button-adjustable pi/2 and free-precession lengths latched at each pump entry.
module pop_timer_core #(
  parameter int PUMP_LEN     = 2500,
  parameter int DEAD_LEN     = 25,
  parameter int PROBE_LEN    = 2500,
  parameter int SAMPLE_DELAY = 250,
  parameter int SAMPLE_LEN   = 1250,
  parameter int P2_DEFAULT   = 25,
  parameter int P2_STEP      = 1,
  parameter int P2_MIN       = 1,
  parameter int P2_MAX       = 250,
  parameter int FP_DEFAULT   = 2500,
  parameter int FP_STEP      = 25,
  parameter int FP_MIN       = 25,
  parameter int FP_MAX       = 25000
) (
  input  logic clock_2_5M,
  input  logic reset,
  input  logic load_defaults,
  input  logic pieovertwo_plus,
  input  logic pieovertwo_minus,
  input  logic freeprecess_plus,
  input  logic freeprecess_minus,
  output logic pump,
  output logic MW,
  output logic probe,
  output logic sample
);

  localparam logic [15:0] PUMP_LEN_C     = 16'(PUMP_LEN);
  localparam logic [15:0] DEAD_LEN_C     = 16'(DEAD_LEN);
  localparam logic [15:0] PROBE_LEN_C    = 16'(PROBE_LEN);
  localparam logic [15:0] SAMPLE_START_C = 16'(SAMPLE_DELAY);
  localparam logic [15:0] SAMPLE_END_C   = 16'(SAMPLE_DELAY + SAMPLE_LEN);
  localparam logic [15:0] P2_DEFAULT_C   = 16'(P2_DEFAULT);
  localparam logic [15:0] P2_STEP_C      = 16'(P2_STEP);
  localparam logic [15:0] P2_MIN_C       = 16'(P2_MIN);
  localparam logic [15:0] P2_MAX_C       = 16'(P2_MAX);
  localparam logic [15:0] FP_DEFAULT_C   = 16'(FP_DEFAULT);
  localparam logic [15:0] FP_STEP_C      = 16'(FP_STEP);
  localparam logic [15:0] FP_MIN_C       = 16'(FP_MIN);
  localparam logic [15:0] FP_MAX_C       = 16'(FP_MAX);

  typedef enum logic [2:0] {
    PH_PUMP  = 3'd0,
    PH_DEAD  = 3'd1,
    PH_MW1   = 3'd2,
    PH_FREE  = 3'd3,
    PH_MW2   = 3'd4,
    PH_PROBE = 3'd5
  } phase_t;

  // Saturating up/down step; opposing requests on the same clock cancel.
  function automatic logic [15:0] step_sat(
    input logic [15:0] val,
    input logic        up,
    input logic        dn,
    input logic [15:0] step,
    input logic [15:0] lo,
    input logic [15:0] hi
  );
    logic [16:0] sum_v;
    sum_v = {1'b0, val} + {1'b0, step};
    if (up && !dn) begin
      if (sum_v > {1'b0, hi}) begin
        step_sat = hi;
      end else begin
        step_sat = sum_v[15:0];
      end
    end else if (dn && !up) begin
      if ({1'b0, val} < ({1'b0, lo} + {1'b0, step})) begin
        step_sat = lo;
      end else begin
        step_sat = val - step;
      end
    end else begin
      step_sat = val;
    end
  endfunction

  // Button order: {fp_minus, fp_plus, p2_minus, p2_plus}
  logic [3:0] btn_s;
  logic [3:0] sync1_r;
  logic [3:0] sync2_r;
  logic [3:0] prev_r;
  logic [3:0] rise_s;

  logic [15:0] p2_r;
  logic [15:0] fp_r;
  logic [15:0] p2_run_r;
  logic [15:0] fp_run_r;

  phase_t      phase_r;
  phase_t      phase_nxt_s;
  logic [15:0] cnt_r;
  logic [15:0] cnt_nxt_s;
  logic [15:0] phase_len_s;
  logic        run_r;
  logic        latch_s;
  logic        pump_nxt_s;
  logic        mw_nxt_s;
  logic        probe_nxt_s;
  logic        sample_nxt_s;

  assign btn_s  = {freeprecess_minus, freeprecess_plus, pieovertwo_minus, pieovertwo_plus};
  assign rise_s = sync2_r & ~prev_r;

  // Two-flop synchronizer followed by the edge-detect history register.
  always_ff @(negedge clock_2_5M or posedge reset) begin
    if (reset) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
      prev_r  <= 4'b0000;
    end else begin
      sync1_r <= btn_s;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Working lengths: defaults dominate, otherwise one saturating step per edge.
  always_ff @(negedge clock_2_5M or posedge reset) begin
    if (reset) begin
      p2_r <= P2_DEFAULT_C;
      fp_r <= FP_DEFAULT_C;
    end else if (load_defaults) begin
      p2_r <= P2_DEFAULT_C;
      fp_r <= FP_DEFAULT_C;
    end else begin
      p2_r <= step_sat(p2_r, rise_s[0], rise_s[1], P2_STEP_C, P2_MIN_C, P2_MAX_C);
      fp_r <= step_sat(fp_r, rise_s[2], rise_s[3], FP_STEP_C, FP_MIN_C, FP_MAX_C);
    end
  end

  // Sequencer state, per-cycle length latches and registered outputs.
  always_ff @(negedge clock_2_5M or posedge reset) begin
    if (reset) begin
      phase_r  <= PH_PUMP;
      cnt_r    <= 16'd0;
      run_r    <= 1'b0;
      p2_run_r <= P2_DEFAULT_C;
      fp_run_r <= FP_DEFAULT_C;
      pump     <= 1'b0;
      MW       <= 1'b0;
      probe    <= 1'b0;
      sample   <= 1'b0;
    end else begin
      phase_r <= phase_nxt_s;
      cnt_r   <= cnt_nxt_s;
      run_r   <= 1'b1;
      if (latch_s) begin
        p2_run_r <= p2_r;
        fp_run_r <= fp_r;
      end else begin
        p2_run_r <= p2_run_r;
        fp_run_r <= fp_run_r;
      end
      pump   <= pump_nxt_s;
      MW     <= mw_nxt_s;
      probe  <= probe_nxt_s;
      sample <= sample_nxt_s;
    end
  end

  // Next phase/count; the first edge after reset enters PUMP at count 0.
  always_comb begin
    phase_nxt_s = phase_r;
    cnt_nxt_s   = cnt_r;
    latch_s     = 1'b0;
    case (phase_r)
      PH_PUMP:  phase_len_s = PUMP_LEN_C;
      PH_DEAD:  phase_len_s = DEAD_LEN_C;
      PH_MW1:   phase_len_s = p2_run_r;
      PH_FREE:  phase_len_s = fp_run_r;
      PH_MW2:   phase_len_s = p2_run_r;
      PH_PROBE: phase_len_s = PROBE_LEN_C;
      default:  phase_len_s = PUMP_LEN_C;
    endcase
    if (!run_r) begin
      phase_nxt_s = PH_PUMP;
      cnt_nxt_s   = 16'd0;
      latch_s     = 1'b1;
    end else if (cnt_r == (phase_len_s - 16'd1)) begin
      cnt_nxt_s = 16'd0;
      case (phase_r)
        PH_PUMP:  phase_nxt_s = PH_DEAD;
        PH_DEAD:  phase_nxt_s = PH_MW1;
        PH_MW1:   phase_nxt_s = PH_FREE;
        PH_FREE:  phase_nxt_s = PH_MW2;
        PH_MW2:   phase_nxt_s = PH_PROBE;
        PH_PROBE: begin
          phase_nxt_s = PH_PUMP;
          latch_s     = 1'b1;
        end
        default: begin
          phase_nxt_s = PH_PUMP;
          latch_s     = 1'b1;
        end
      endcase
    end else begin
      cnt_nxt_s = cnt_r + 16'd1;
    end
  end

  // Output decode of the state being entered, so outputs change on that same edge.
  always_comb begin
    pump_nxt_s   = (phase_nxt_s == PH_PUMP);
    mw_nxt_s     = (phase_nxt_s == PH_MW1) || (phase_nxt_s == PH_MW2);
    probe_nxt_s  = (phase_nxt_s == PH_PROBE);
    sample_nxt_s = (phase_nxt_s == PH_PROBE) && (cnt_nxt_s >= SAMPLE_START_C)
                   && (cnt_nxt_s < SAMPLE_END_C);
  end

endmodule

// File: tb/tb_pop_timer_core.sv
// Directed bench for pop_timer_core: measures phase lengths of whole cycles
// against hand-computed durations for default, stepped, saturated and reset cases.
module tb_pop_timer_core;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load_defaults = 1'b0;
  logic p2_plus = 1'b0;
  logic p2_minus = 1'b0;
  logic fp_plus = 1'b0;
  logic fp_minus = 1'b0;
  logic pump, MW, probe, sample;

  int n_pass = 0;
  int n_total = 0;
  int d_len[6];
  int s_start, s_len, n_bad, period;
  bit timed_out;

  pop_timer_core dut (
    .clock_2_5M       (clk),
    .reset            (reset),
    .load_defaults    (load_defaults),
    .pieovertwo_plus  (p2_plus),
    .pieovertwo_minus (p2_minus),
    .freeprecess_plus (fp_plus),
    .freeprecess_minus(fp_minus),
    .pump             (pump),
    .MW               (MW),
    .probe            (probe),
    .sample           (sample)
  );

  always #200 clk = ~clk;

  initial begin
    #(400 * 95000);
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // Called at the rising-edge sample where pump is first seen high; returns at the next one.
  task automatic measure_cycle();
    int seg;
    int guard;
    bit done;
    logic [2:0] exp_v;
    d_len = '{1, 0, 0, 0, 0, 0};
    s_start = -1; s_len = 0; n_bad = 0; seg = 0; guard = 0; done = 0; timed_out = 0;
    while (!done && !timed_out) begin
      @(posedge clk);
      guard++;
      if (guard > 40000) timed_out = 1;
      case (seg)
        0: if (pump) d_len[0]++; else if (MW) begin seg = 2; d_len[2] = 1; end else begin seg = 1; d_len[1] = 1; end
        1: if (MW) begin seg = 2; d_len[2] = 1; end else d_len[1]++;
        2: if (MW) d_len[2]++; else begin seg = 3; d_len[3] = 1; end
        3: if (MW) begin seg = 4; d_len[4] = 1; end else d_len[3]++;
        4: if (MW) d_len[4]++; else begin seg = 5; d_len[5] = 1; end
        default: if (pump) done = 1; else d_len[5]++;
      endcase
      if (!done) begin
        case (seg)
          0: exp_v = 3'b100;
          2, 4: exp_v = 3'b010;
          5: exp_v = 3'b001;
          default: exp_v = 3'b000;
        endcase
        if ({pump, MW, probe} !== exp_v) n_bad++;
        if (sample && seg != 5) n_bad++;
        if (sample && seg == 5) begin
          if (s_start < 0) s_start = d_len[5] - 1;
          s_len++;
        end
      end
    end
    period = d_len[0] + d_len[1] + d_len[2] + d_len[3] + d_len[4] + d_len[5];
    if (timed_out) begin
      n_total++;
      $display("FAIL cycle_timeout no pump rise within 40000 clocks");
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if ({pump, MW, probe, sample} !== 4'b0000) $display("FAIL reset_outputs got %b exp 0000", {pump, MW, probe, sample}); else n_pass++;
    reset = 1'b0;
    #100;
    n_total++; if (pump !== 1'b0) $display("FAIL pre_first_edge got %b exp 0", pump); else n_pass++;
    @(posedge clk);
    n_total++; if (pump !== 1'b1) $display("FAIL first_edge_pump got %b exp 1", pump); else n_pass++;
    repeat (100) @(posedge clk);
    #100 reset = 1'b1;
    #1;
    n_total++; if (pump !== 1'b0) $display("FAIL async_reset_pump got %b exp 0", pump); else n_pass++;
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    n_total++; if (pump !== 1'b1) $display("FAIL restart_pump got %b exp 1", pump); else n_pass++;
    measure_cycle();
    n_total++; if (d_len[0] !== 2500) $display("FAIL dflt_pump got %0d exp 2500", d_len[0]); else n_pass++;
    n_total++; if (d_len[1] !== 25) $display("FAIL dflt_dead got %0d exp 25", d_len[1]); else n_pass++;
    n_total++; if (d_len[2] !== 25) $display("FAIL dflt_mw1 got %0d exp 25", d_len[2]); else n_pass++;
    n_total++; if (d_len[3] !== 2500) $display("FAIL dflt_free got %0d exp 2500", d_len[3]); else n_pass++;
    n_total++; if (d_len[4] !== 25) $display("FAIL dflt_mw2 got %0d exp 25", d_len[4]); else n_pass++;
    n_total++; if (d_len[5] !== 2500) $display("FAIL dflt_probe got %0d exp 2500", d_len[5]); else n_pass++;
    n_total++; if (s_start !== 250) $display("FAIL sample_start got %0d exp 250", s_start); else n_pass++;
    n_total++; if (s_len !== 1250) $display("FAIL sample_len got %0d exp 1250", s_len); else n_pass++;
    n_total++; if (period !== 7575) $display("FAIL dflt_period got %0d exp 7575", period); else n_pass++;
    n_total++; if (n_bad !== 0) $display("FAIL output_exclusive got %0d exp 0", n_bad); else n_pass++;
  endtask

  task automatic test_p2_plus_during_free();
    fork
      measure_cycle();
      begin
        repeat (2650) @(posedge clk);
        p2_plus = 1'b1;
        repeat (4) @(posedge clk);
        p2_plus = 1'b0;
      end
    join
    n_total++; if (d_len[2] !== 25) $display("FAIL cur_mw1 got %0d exp 25", d_len[2]); else n_pass++;
    n_total++; if (d_len[4] !== 25) $display("FAIL cur_mw2 got %0d exp 25", d_len[4]); else n_pass++;
    n_total++; if (period !== 7575) $display("FAIL cur_period got %0d exp 7575", period); else n_pass++;
    measure_cycle();
    n_total++; if (d_len[2] !== 26) $display("FAIL next_mw1 got %0d exp 26", d_len[2]); else n_pass++;
    n_total++; if (d_len[4] !== 26) $display("FAIL next_mw2 got %0d exp 26", d_len[4]); else n_pass++;
    n_total++; if (period !== 7577) $display("FAIL next_period got %0d exp 7577", period); else n_pass++;
  endtask

  task automatic test_fp_minus_held();
    int free_a, per_a;
    fork
      begin
        measure_cycle();
        free_a = d_len[3];
        per_a = period;
        measure_cycle();
      end
      begin
        fp_minus = 1'b1;
        repeat (10000) @(posedge clk);
        fp_minus = 1'b0;
      end
    join
    n_total++; if (free_a !== 2500) $display("FAIL held_cur_free got %0d exp 2500", free_a); else n_pass++;
    n_total++; if (per_a !== 7577) $display("FAIL held_cur_period got %0d exp 7577", per_a); else n_pass++;
    n_total++; if (d_len[3] !== 2475) $display("FAIL held_next_free got %0d exp 2475", d_len[3]); else n_pass++;
    n_total++; if (period !== 7552) $display("FAIL held_next_period got %0d exp 7552", period); else n_pass++;
  endtask

  task automatic test_saturation();
    fork
      measure_cycle();
      for (int i = 0; i < 300; i++) begin
        p2_plus = 1'b1;
        repeat (3) @(posedge clk);
        p2_plus = 1'b0;
        repeat (3) @(posedge clk);
      end
    join
    n_total++; if (d_len[3] !== 2475) $display("FAIL no_autorepeat_free got %0d exp 2475", d_len[3]); else n_pass++;
    n_total++; if (d_len[2] !== 26) $display("FAIL sat_cur_mw1 got %0d exp 26", d_len[2]); else n_pass++;
    fork
      measure_cycle();
      for (int i = 0; i < 100; i++) begin
        fp_minus = 1'b1;
        repeat (3) @(posedge clk);
        fp_minus = 1'b0;
        repeat (3) @(posedge clk);
      end
    join
    n_total++; if (d_len[2] !== 250) $display("FAIL p2_sat_mw1 got %0d exp 250", d_len[2]); else n_pass++;
    n_total++; if (d_len[4] !== 250) $display("FAIL p2_sat_mw2 got %0d exp 250", d_len[4]); else n_pass++;
    n_total++; if (d_len[3] !== 2475) $display("FAIL sat_cur_free got %0d exp 2475", d_len[3]); else n_pass++;
    n_total++; if (period !== 8000) $display("FAIL sat_period got %0d exp 8000", period); else n_pass++;
  endtask

  task automatic test_load_defaults();
    fork
      measure_cycle();
      begin
        repeat (10) @(posedge clk);
        load_defaults = 1'b1;
        repeat (10) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
          p2_plus = 1'b1;
          repeat (4) @(posedge clk);
          p2_plus = 1'b0;
          repeat (4) @(posedge clk);
        end
        repeat (10) @(posedge clk);
        load_defaults = 1'b0;
        repeat (10) @(posedge clk);
        p2_plus = 1'b1;
        p2_minus = 1'b1;
        repeat (4) @(posedge clk);
        p2_plus = 1'b0;
        p2_minus = 1'b0;
      end
    join
    n_total++; if (d_len[3] !== 25) $display("FAIL fp_sat_free got %0d exp 25", d_len[3]); else n_pass++;
    n_total++; if (d_len[2] !== 250) $display("FAIL load_cur_mw1 got %0d exp 250", d_len[2]); else n_pass++;
    n_total++; if (period !== 5550) $display("FAIL load_cur_period got %0d exp 5550", period); else n_pass++;
    measure_cycle();
    n_total++; if (d_len[2] !== 25) $display("FAIL load_next_mw1 got %0d exp 25", d_len[2]); else n_pass++;
    n_total++; if (d_len[4] !== 25) $display("FAIL load_next_mw2 got %0d exp 25", d_len[4]); else n_pass++;
    n_total++; if (d_len[3] !== 2500) $display("FAIL load_next_free got %0d exp 2500", d_len[3]); else n_pass++;
    n_total++; if (period !== 7575) $display("FAIL load_next_period got %0d exp 7575", period); else n_pass++;
  endtask

  task automatic test_reset_mid_free();
    repeat (20) @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      p2_plus = 1'b1;
      repeat (4) @(posedge clk);
      p2_plus = 1'b0;
      repeat (4) @(posedge clk);
    end
    repeat (2650 - 36) @(posedge clk);
    #100 reset = 1'b1;
    #1;
    n_total++; if ({pump, MW, probe, sample} !== 4'b0000) $display("FAIL midfree_reset_outputs got %b exp 0000", {pump, MW, probe, sample}); else n_pass++;
    @(posedge clk);
    #1 reset = 1'b0;
    #100;
    n_total++; if (pump !== 1'b0) $display("FAIL midfree_pre_edge got %b exp 0", pump); else n_pass++;
    @(posedge clk);
    n_total++; if (pump !== 1'b1) $display("FAIL midfree_first_pump got %b exp 1", pump); else n_pass++;
    measure_cycle();
    n_total++; if (d_len[0] !== 2500) $display("FAIL rst_pump got %0d exp 2500", d_len[0]); else n_pass++;
    n_total++; if (d_len[1] !== 25) $display("FAIL rst_dead got %0d exp 25", d_len[1]); else n_pass++;
    n_total++; if (d_len[2] !== 25) $display("FAIL rst_mw1 got %0d exp 25", d_len[2]); else n_pass++;
    n_total++; if (d_len[3] !== 2500) $display("FAIL rst_free got %0d exp 2500", d_len[3]); else n_pass++;
    n_total++; if (d_len[4] !== 25) $display("FAIL rst_mw2 got %0d exp 25", d_len[4]); else n_pass++;
    n_total++; if (d_len[5] !== 2500) $display("FAIL rst_probe got %0d exp 2500", d_len[5]); else n_pass++;
    n_total++; if (period !== 7575) $display("FAIL rst_period got %0d exp 7575", period); else n_pass++;
    n_total++; if (n_bad !== 0) $display("FAIL rst_exclusive got %0d exp 0", n_bad); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_p2_plus_during_free();
    test_fp_minus_held();
    test_saturation();
    test_load_defaults();
    test_reset_mid_free();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
